// File: rtl/cache_pkg.sv
// Shared types and constants for the trace-driven cache model front end.
package cache_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 12;
  localparam int unsigned DIV_W_DEF  = 22;

  localparam int unsigned BLOCKSIZE  = 64;
  localparam int unsigned PERMILLE   = 1000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DIV   = 3'd3,
    DONE  = 3'd4
  } sched_state_t;

endpackage

// File: rtl/cache_rate_div.sv
// Start/done restoring serial divider, one quotient bit per cycle, with
// zero-divisor guard and saturation of the quotient to Q_W bits.
module cache_rate_div #(
  parameter int unsigned NUM_W = 22,
  parameter int unsigned DEN_W = 13,
  parameter int unsigned Q_W   = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quot
);

  localparam int unsigned STEP_W = $clog2(NUM_W);

  logic [NUM_W-1:0]  dvd;
  logic [DEN_W-1:0]  rem;
  logic [DEN_W-1:0]  den_q;
  logic              den_zero;
  logic [STEP_W-1:0] step;

  logic [DEN_W:0]    rem_shift_c;
  logic [DEN_W:0]    rem_diff_c;
  logic              sub_ok_c;
  logic [DEN_W-1:0]  rem_next_c;
  logic [NUM_W-1:0]  dvd_next_c;
  logic [Q_W-1:0]    result_c;

  // One restoring step; the borrow bit of the trial subtraction picks the quotient bit.
  always_comb begin
    rem_shift_c = {rem, dvd[NUM_W-1]};
    rem_diff_c  = rem_shift_c - {1'b0, den_q};
    sub_ok_c    = ~rem_diff_c[DEN_W];
    rem_next_c  = sub_ok_c ? rem_diff_c[DEN_W-1:0] : rem_shift_c[DEN_W-1:0];
    dvd_next_c  = {dvd[NUM_W-2:0], sub_ok_c};
    if (den_zero) begin
      result_c = '0;
    end else if (|dvd_next_c[NUM_W-1:Q_W]) begin
      result_c = '1;
    end else begin
      result_c = dvd_next_c[Q_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      quot     <= '0;
      dvd      <= '0;
      rem      <= '0;
      den_q    <= '0;
      den_zero <= 1'b0;
      step     <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        dvd      <= num;
        rem      <= '0;
        den_q    <= den;
        den_zero <= (den == '0);
        step     <= '0;
        busy     <= 1'b1;
      end else if (busy) begin
        dvd  <= dvd_next_c;
        rem  <= rem_next_c;
        step <= step + STEP_W'(1);
        if (step == STEP_W'(NUM_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
          quot <= result_c;
        end
      end
    end
  end

endmodule

// File: rtl/cache_access_sched.sv
// Round-robin read/write scheduler feeding the cache lookup engine, with
// saturating access/miss counters and an on-demand per-mille miss rate.
module cache_access_sched
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned DIV_W  = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_ready,
  output logic              cache_req_valid,
  output logic [ADDR_W-1:0] cache_req_addr,
  output logic              cache_req_we,
  input  logic              cache_req_ready,
  input  logic              cache_resp_valid,
  input  logic              cache_resp_hit,
  input  logic              stat_req,
  output logic              stat_done,
  output logic              busy,
  output logic [CNT_W-1:0]  num_reads,
  output logic [CNT_W-1:0]  num_writes,
  output logic [CNT_W-1:0]  num_misses,
  output logic [CNT_W-1:0]  cache_miss_rate
);

  localparam int unsigned DEN_W = CNT_W + 1;

  sched_state_t     state, state_next;
  logic             rr_ptr, rr_ptr_next;
  logic             grant_rd_c, grant_wr_c;
  logic             div_start_c;
  logic             div_busy, div_done;
  logic [CNT_W-1:0] div_quot;
  logic [DIV_W-1:0] div_num_c;
  logic [DEN_W-1:0] div_den_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign div_num_c = DIV_W'(num_misses) * DIV_W'(PERMILLE);
  assign div_den_c = DEN_W'(num_reads) + DEN_W'(num_writes);

  assign rd_ready = grant_rd_c;
  assign wr_ready = grant_wr_c;

  // Next state, arbitration and divider kick-off; rr_ptr=1 favours the writer.
  always_comb begin
    state_next  = state;
    rr_ptr_next = rr_ptr;
    grant_rd_c  = 1'b0;
    grant_wr_c  = 1'b0;
    div_start_c = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (rd_valid && wr_valid) begin
            grant_rd_c  = ~rr_ptr;
            grant_wr_c  = rr_ptr;
            rr_ptr_next = ~rr_ptr;
            state_next  = ISSUE;
          end else if (rd_valid) begin
            grant_rd_c = 1'b1;
            state_next = ISSUE;
          end else if (wr_valid) begin
            grant_wr_c = 1'b1;
            state_next = ISSUE;
          end else if (stat_req) begin
            state_next = DIV;
          end
        end
        ISSUE: begin
          if (cache_req_ready) state_next = WAIT;
        end
        WAIT: begin
          if (cache_resp_valid) state_next = IDLE;
        end
        DIV: begin
          if (div_done) begin
            state_next = DONE;
          end else if (!div_busy) begin
            div_start_c = 1'b1;
          end
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      rr_ptr          <= 1'b0;
      busy            <= 1'b0;
      cache_req_valid <= 1'b0;
      cache_req_addr  <= '0;
      cache_req_we    <= 1'b0;
      num_reads       <= '0;
      num_writes      <= '0;
      num_misses      <= '0;
      cache_miss_rate <= '0;
      stat_done       <= 1'b0;
    end else begin
      state     <= state_next;
      rr_ptr    <= rr_ptr_next;
      busy      <= (state_next != IDLE);
      stat_done <= 1'b0;

      if (grant_rd_c || grant_wr_c) begin
        cache_req_valid <= 1'b1;
        cache_req_addr  <= grant_wr_c ? wr_addr : rd_addr;
        cache_req_we    <= grant_wr_c;
        if (grant_wr_c) num_writes <= sat_inc(num_writes);
        else            num_reads  <= sat_inc(num_reads);
      end else if (state == ISSUE && cache_req_ready) begin
        cache_req_valid <= 1'b0;
      end

      // Responses only count while an access is outstanding.
      if (state == WAIT && cache_resp_valid && !cache_resp_hit) begin
        num_misses <= sat_inc(num_misses);
      end

      if (state == DIV && div_done) begin
        cache_miss_rate <= div_quot;
        stat_done       <= 1'b1;
      end
    end
  end

  cache_rate_div #(
    .NUM_W (DIV_W),
    .DEN_W (DEN_W),
    .Q_W   (CNT_W)
  ) u_rate_div (
    .clk   (clk),
    .reset (reset),
    .start (div_start_c),
    .num   (div_num_c),
    .den   (div_den_c),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (div_quot)
  );

endmodule

// File: tb/tb_cache_access_sched.sv
// Bench for cache_access_sched: directed table, corner sequences and a
// randomized run against an arithmetic reference of the scheduler rules.
module tb_cache_access_sched;
  import cache_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 12;
  localparam int unsigned DIV_W  = 22;
  localparam int          CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              rd_valid, wr_valid;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic              rd_ready, wr_ready;
  logic              cache_req_valid, cache_req_we, cache_req_ready;
  logic [ADDR_W-1:0] cache_req_addr;
  logic              cache_resp_valid, cache_resp_hit;
  logic              stat_req, stat_done, busy;
  logic [CNT_W-1:0]  num_reads, num_writes, num_misses, cache_miss_rate;

  int n_vec = 0;
  int n_err = 0;

  cache_access_sched #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .rd_valid         (rd_valid),
    .rd_addr          (rd_addr),
    .rd_ready         (rd_ready),
    .wr_valid         (wr_valid),
    .wr_addr          (wr_addr),
    .wr_ready         (wr_ready),
    .cache_req_valid  (cache_req_valid),
    .cache_req_addr   (cache_req_addr),
    .cache_req_we     (cache_req_we),
    .cache_req_ready  (cache_req_ready),
    .cache_resp_valid (cache_resp_valid),
    .cache_resp_hit   (cache_resp_hit),
    .stat_req         (stat_req),
    .stat_done        (stat_done),
    .busy             (busy),
    .num_reads        (num_reads),
    .num_writes       (num_writes),
    .num_misses       (num_misses),
    .cache_miss_rate  (cache_miss_rate)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rv;
    bit wv;
    bit hit;
    bit stat;
    bit exp_we;
    int exp_r;
    int exp_w;
    int exp_m;
    int exp_rate;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic int rate_ref(input int r, input int w, input int m);
    int q;
    if (r + w == 0) return 0;
    q = (m * 1000) / (r + w);
    return (q > CMAX) ? CMAX : q;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    rd_valid = 0; wr_valid = 0; cache_req_ready = 0;
    cache_resp_valid = 0; cache_resp_hit = 0; stat_req = 0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic check_counts(input int r, input int w, input int m);
    check("num_reads", num_reads, r);
    check("num_writes", num_writes, w);
    check("num_misses", num_misses, m);
  endtask

  // One complete access from an IDLE cycle: grant, optional stall, response.
  task automatic do_access(input bit rv, input bit wv, input bit hit, input int stall,
                           input int lat, input bit hold, input bit stray,
                           input bit exp_we, input logic [31:0] ra, input logic [31:0] wa);
    logic [31:0] exp_addr;
    exp_addr = exp_we ? wa : ra;
    rd_valid = rv; wr_valid = wv; rd_addr = ra; wr_addr = wa;
    cache_req_ready = 0;
    #1;
    check("rd_ready_grant", rd_ready, !exp_we);
    check("wr_ready_grant", wr_ready, exp_we);
    check("req_valid_in_grant_cycle", cache_req_valid, 0);
    tick();
    if (!hold) begin rd_valid = 0; wr_valid = 0; end
    check("req_valid_issue", cache_req_valid, 1);
    check("req_addr", cache_req_addr, exp_addr);
    check("req_we", cache_req_we, exp_we);
    check("busy_issue", busy, 1);
    for (int k = 0; k < stall; k++) begin
      cache_resp_valid = stray && (k == 0);
      cache_resp_hit = 0;
      tick();
      cache_resp_valid = 0;
      check("req_valid_stall", cache_req_valid, 1);
      check("req_addr_stall", cache_req_addr, exp_addr);
      check("readies_stall", {rd_ready, wr_ready}, 0);
    end
    cache_req_ready = 1;
    tick();
    cache_req_ready = 0;
    check("req_valid_wait", cache_req_valid, 0);
    check("busy_wait", busy, 1);
    for (int k = 0; k < lat; k++) begin
      tick();
      check("readies_wait", {rd_ready, wr_ready}, 0);
    end
    cache_resp_valid = 1; cache_resp_hit = hit;
    tick();
    cache_resp_valid = 0; cache_resp_hit = 0;
    check("busy_after_resp", busy, 0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!stat_done && n < 200) begin
      tick();
      n++;
    end
  endtask

  // Miss-rate request from IDLE; latency counted from the first DIV cycle.
  task automatic do_stat(input int exp_rate, input bit hold);
    int n;
    stat_req = 1;
    tick();
    check("div_entry_busy", busy, 1);
    if (!hold) stat_req = 0;
    wait_done(n);
    check("stat_latency", n, DIV_W + 2);
    check("miss_rate", cache_miss_rate, exp_rate);
    tick();
    check("stat_done_pulse", stat_done, 0);
    check("idle_after_done", busy, 0);
    if (hold) begin
      n = 0;
      while (!busy && n < 10) begin tick(); n++; end
      check("restart_after_gap", busy, 1);
      stat_req = 0;
      wait_done(n);
      check("stat_latency_repeat", n, DIV_W + 2);
      check("miss_rate_repeat", cache_miss_rate, exp_rate);
      tick();
      check("idle_after_repeat", busy, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    bit fav_wr, rv, wv, hit, ew;
    int mr, mw, mm;

    // Hand-derived expectations; round robin starts with the reader favoured.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1, 0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1, 1, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1, 1, 0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2, 2, 2, 0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3, 2, 2, 0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4, 2, 3, 0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4, 3, 3, 0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4, 4, 3, 0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4, 4, 3, 375};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5, 4, 4, 0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5, 4, 4, 444};

    rd_addr = '0; wr_addr = '0;
    do_reset();

    // Reset values, with both requesters asserting during reset.
    reset = 1; rd_valid = 1; wr_valid = 1;
    tick();
    #1;
    check("rst_readies", {rd_ready, wr_ready}, 0);
    check("rst_busy", busy, 0);
    check("rst_req_valid", cache_req_valid, 0);
    check("rst_req_addr", cache_req_addr, 0);
    check("rst_req_we", cache_req_we, 0);
    check("rst_stat_done", stat_done, 0);
    check("rst_rate", cache_miss_rate, 0);
    check_counts(0, 0, 0);
    do_reset();

    // Single read with an immediately ready engine.
    do_access(1, 0, 0, 0, 1, 0, 0, 0, 32'h0000_1040, 32'h0);
    check_counts(1, 0, 1);

    // Directed table.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].stat) begin
        do_stat(tbl[i].exp_rate, 0);
      end else begin
        do_access(tbl[i].rv, tbl[i].wv, tbl[i].hit, i % 3, i % 2, 0, 0, tbl[i].exp_we,
                  32'h0000_1000 + 32'(BLOCKSIZE * i), 32'h8000_0000 + 32'(BLOCKSIZE * i));
      end
      check_counts(tbl[i].exp_r, tbl[i].exp_w, tbl[i].exp_m);
    end

    // Contention with both valids held: R, W, R, W, then a backpressured R.
    do_reset();
    for (int i = 0; i < 4; i++)
      do_access(1, 1, 1, 0, 0, 1, 0, bit'(i % 2), 32'h0000_2000, 32'h0000_3000);
    check_counts(2, 2, 0);
    do_access(1, 1, 1, 5, 0, 1, 0, 0, 32'h0000_2040, 32'h0000_3040);
    rd_valid = 0; wr_valid = 0;
    check_counts(3, 2, 0);

    // 3 reads + 1 write with one miss, stat_req held across completion.
    do_reset();
    do_access(1, 0, 1, 0, 0, 0, 0, 0, 32'h100, 32'h0);
    do_access(1, 0, 0, 0, 2, 0, 0, 0, 32'h140, 32'h0);
    do_access(0, 1, 1, 1, 0, 0, 0, 1, 32'h0, 32'h180);
    do_access(1, 0, 1, 0, 0, 0, 0, 0, 32'h1c0, 32'h0);
    do_stat(250, 1);
    check_counts(3, 1, 1);

    // Rate with no accesses.
    do_reset();
    do_stat(0, 0);

    // Reset during WAIT, then a stray response.
    do_reset();
    rd_valid = 1; rd_addr = 32'h0000_5000;
    tick();
    rd_valid = 0; cache_req_ready = 1;
    tick();
    cache_req_ready = 0;
    reset = 1;
    tick();
    reset = 0;
    check("midwait_rst_busy", busy, 0);
    check("midwait_rst_valid", cache_req_valid, 0);
    check_counts(0, 0, 0);
    cache_resp_valid = 1; cache_resp_hit = 0;
    tick();
    cache_resp_valid = 0;
    check("stray_resp_busy", busy, 0);
    check_counts(0, 0, 0);

    // Randomized traffic against the reference model.
    do_reset();
    fav_wr = 0; mr = 0; mw = 0; mm = 0;
    for (int t = 0; t < 300; t++) begin
      rv = 1'($urandom_range(0, 1));
      wv = 1'($urandom_range(0, 1));
      if (!rv && !wv) begin
        #1;
        check("idle_readies", {rd_ready, wr_ready}, 0);
        tick();
        check("idle_busy", busy, 0);
        continue;
      end
      if (rv && wv) begin
        ew = fav_wr;
        fav_wr = !fav_wr;
      end else begin
        ew = wv;
      end
      hit = 1'($urandom_range(0, 1));
      do_access(rv, wv, hit, $urandom_range(0, 3), $urandom_range(0, 3), 0,
                ($urandom_range(0, 3) == 0), ew, $urandom(), $urandom());
      if (ew) mw = sat(mw); else mr = sat(mr);
      if (!hit) mm = sat(mm);
      check_counts(mr, mw, mm);
      if (t % 25 == 24) do_stat(rate_ref(mr, mw, mm), 0);
    end

    // Counter saturation: 4100 missing reads.
    do_reset();
    for (int i = 0; i < 4100; i++)
      do_access(1, 0, 0, 0, 0, 0, 0, 0, 32'(i * BLOCKSIZE), 32'h0);
    check_counts(CMAX, 0, CMAX);
    do_stat(1000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
